// File: rtl/div_unit_pkg.sv
// Shared state encoding and default widths for the radix-2 restoring divider.
// DIV_BYZERO_FAST_EN adds the BYZERO state used by the divide-by-zero shortcut.
package div_unit_pkg;

   localparam int DIV_DATA_W = 32;
   localparam int DIV_CNT_W  = 6;

   typedef enum logic [1:0] {
      DIV_FREE   = 2'b00,
`ifdef DIV_BYZERO_FAST_EN
      DIV_BYZERO = 2'b01,
`endif
      DIV_ON     = 2'b10,
      DIV_END    = 2'b11
   } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring iteration: subtract the divisor from {partial remainder, next bit}
// and keep the difference only when it does not go negative.
module div_step #(
   parameter int W = 32
) (
   input  logic [W:0]   i_part,
   input  logic [W-1:0] i_dvs,
   output logic [W-1:0] o_rem,
   output logic         o_qbit
);

   logic [W:0] w_trial;

   assign w_trial = i_part - {1'b0, i_dvs};
   assign o_qbit  = ~w_trial[W];
   assign o_rem   = o_qbit ? w_trial[W-1:0] : i_part[W-1:0];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned divider beside Ex; result_o = {remainder, quotient}.
// Define DIV_BYZERO_FAST_EN to answer a zero divisor in two cycles with an all-zero result.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int DATA_W = DIV_DATA_W,
   parameter int CNT_W  = DIV_CNT_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                signed_div_i,
   input  logic [DATA_W-1:0]   opdata1_i,
   input  logic [DATA_W-1:0]   opdata2_i,
   input  logic                start_i,
   input  logic                annul_i,
   output logic [2*DATA_W-1:0] result_o,
   output logic                ready_o
);

   div_state_e          r_state;
   div_state_e          w_next;
   logic [CNT_W-1:0]    r_cnt;
   logic [DATA_W-1:0]   r_rem;
   logic [DATA_W-1:0]   r_quo;
   logic [DATA_W-1:0]   r_dvs;
   logic                r_neg_q;
   logic                r_neg_r;
   logic                r_ready;
   logic [2*DATA_W-1:0] r_result;

   logic                w_dvd_neg;
   logic                w_dvs_neg;
   logic [DATA_W-1:0]   w_dvd_abs;
   logic [DATA_W-1:0]   w_dvs_abs;
   logic [DATA_W-1:0]   w_rem;
   logic                w_qbit;
   logic [DATA_W-1:0]   w_quo_nxt;
   logic [DATA_W-1:0]   w_quo_fix;
   logic [DATA_W-1:0]   w_rem_fix;
   logic                w_last;
   logic                w_go;
`ifdef DIV_BYZERO_FAST_EN
   logic                w_byzero;

   assign w_byzero = (opdata2_i == '0);
`endif

   assign w_dvd_neg = signed_div_i & opdata1_i[DATA_W-1];
   assign w_dvs_neg = signed_div_i & opdata2_i[DATA_W-1];
   assign w_dvd_abs = w_dvd_neg ? -opdata1_i : opdata1_i;
   assign w_dvs_abs = w_dvs_neg ? -opdata2_i : opdata2_i;
   assign w_go      = start_i & ~annul_i;
   assign w_last    = (r_cnt == CNT_W'(DATA_W - 1));

   // r_quo shifts dividend bits out at the top and quotient bits in at the bottom
   div_step #(.W(DATA_W)) u_step (
      .i_part (({r_rem, r_quo[DATA_W-1]})),
      .i_dvs  (r_dvs),
      .o_rem  (w_rem),
      .o_qbit (w_qbit)
   );

   assign w_quo_nxt = {r_quo[DATA_W-2:0], w_qbit};
   assign w_quo_fix = r_neg_q ? -w_quo_nxt : w_quo_nxt;
   assign w_rem_fix = r_neg_r ? -w_rem : w_rem;

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         DIV_FREE:
            if (w_go) begin
`ifdef DIV_BYZERO_FAST_EN
               w_next = w_byzero ? DIV_BYZERO : DIV_ON;
`else
               w_next = DIV_ON;
`endif
            end
`ifdef DIV_BYZERO_FAST_EN
         DIV_BYZERO: w_next = DIV_END;
`endif
         DIV_ON:     if (w_last) w_next = DIV_END;
         DIV_END:    if (!start_i) w_next = DIV_FREE;
         default:    w_next = DIV_FREE;
      endcase
      if (annul_i) w_next = DIV_FREE;
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= DIV_FREE;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_dvs    <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_ready  <= 1'b0;
         r_result <= '0;
      end else begin
         r_ready <= (w_next == DIV_END);
         // result is captured once on the final step and held through END
         if (w_next != DIV_END)
            r_result <= '0;
         else if (r_state == DIV_ON)
            r_result <= {w_rem_fix, w_quo_fix};
         if (r_state == DIV_FREE && w_go) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= w_dvd_abs;
            r_dvs   <= w_dvs_abs;
            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r <= w_dvd_neg;
         end else if (r_state == DIV_ON) begin
            r_cnt <= r_cnt + 1'b1;
            r_rem <= w_rem;
            r_quo <= w_quo_nxt;
         end
      end
   end

   assign ready_o  = r_ready;
   assign result_o = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Random and directed checks of div_unit against an arithmetic reference model.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   int n_tot = 0;
   int n_bad = 0;

   div_unit dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                           input logic [31:0] b);
      longint sa, sb, q, r;
`ifdef DIV_BYZERO_FAST_EN
      if (b == 32'd0) return 64'd0;
`endif
      if (!sgn) begin
         if (b == 32'd0) return {a, 32'hFFFF_FFFF};
         return {a % b, a / b};
      end
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sb == 0) return {a, (sa < 0) ? 32'd1 : 32'hFFFF_FFFF};
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   function automatic int lat_of(input logic [31:0] b);
`ifdef DIV_BYZERO_FAST_EN
      if (b == 32'd0) return 1;
`endif
      return 32;
   endfunction

   // edges after the start-sampling edge until ready_o is seen
   task automatic wait_ready(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!ready_o && n < 40);
   endtask

   task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int hold, input string tag);
      int n;
      @(negedge clk);
      signed_div_i = sgn;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      signed_div_i = 1'($urandom);
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      wait_ready(n);
      chk({tag, " lat"}, 64'(n), 64'(lat_of(b)));
      chk(tag, result_o, exp);
      repeat (hold) begin
         @(posedge clk);
         #1;
         chk({tag, " hold rdy"}, 64'(ready_o), 64'd1);
         chk({tag, " hold res"}, result_o, exp);
      end
      @(negedge clk);
      start_i = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, " drop rdy"}, 64'(ready_o), 64'd0);
      chk({tag, " drop res"}, result_o, 64'd0);
   endtask

   logic [31:0] specials [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

   function automatic logic [31:0] pick(input int mode);
      unique case (mode)
         0:       return $urandom;
         1:       return $urandom_range(0, 20);
         2:       return $urandom_range(1, 300);
         default: return specials[$urandom_range(0, 4)];
      endcase
   endfunction

   initial begin
      int n;
      logic        s;
      logic [31:0] a, b;
      logic [63:0] bz_u, bz_s;
`ifdef DIV_BYZERO_FAST_EN
      bz_u = 64'd0;
      bz_s = 64'd0;
`else
      bz_u = {32'd5, 32'hFFFF_FFFF};
      bz_s = {32'hFFFF_FFFB, 32'd1};
`endif
      rst = 1'b1;
      signed_div_i = 1'b0;
      opdata1_i = '0;
      opdata2_i = '0;
      start_i = 1'b0;
      annul_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset rdy", 64'(ready_o), 64'd0);
      chk("reset res", result_o, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      do_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 0, "u100/7");
      do_div(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1, "s-7/2");
      do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 0, "s ovf");
      do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0}, 0, "u big");
      do_div(1'b0, 32'd5, 32'd0, bz_u, 0, "u5/0");
      do_div(1'b1, 32'hFFFF_FFFB, 32'd0, bz_s, 0, "s-5/0");
      do_div(1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 3, "s-100/7");

      // annul while dividing
      @(negedge clk);
      signed_div_i = 1'b0;
      opdata1_i = 32'd100;
      opdata2_i = 32'd7;
      start_i = 1'b1;
      @(posedge clk);
      repeat (9) @(posedge clk);
      @(negedge clk);
      annul_i = 1'b1;
      start_i = 1'b0;
      @(posedge clk);
      #1;
      chk("annul on rdy", 64'(ready_o), 64'd0);
      @(negedge clk);
      annul_i = 1'b0;
      do_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 0, "after annul");

      // annul in FREE blocks start
      @(negedge clk);
      annul_i = 1'b1;
      start_i = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("annul free rdy", 64'(ready_o), 64'd0);
      end
      @(negedge clk);
      annul_i = 1'b0;
      start_i = 1'b0;
      do_div(1'b0, 32'd50, 32'd6, {32'd2, 32'd8}, 0, "after free annul");

      // annul in END
      @(negedge clk);
      signed_div_i = 1'b0;
      opdata1_i = 32'd9;
      opdata2_i = 32'd3;
      start_i = 1'b1;
      @(posedge clk);
      wait_ready(n);
      chk("end annul lat", 64'(n), 64'd32);
      @(negedge clk);
      annul_i = 1'b1;
      @(posedge clk);
      #1;
      chk("end annul rdy", 64'(ready_o), 64'd0);
      chk("end annul res", result_o, 64'd0);
      @(negedge clk);
      annul_i = 1'b0;
      start_i = 1'b0;

      // start dropped mid-operation: one-cycle ready pulse
      @(negedge clk);
      signed_div_i = 1'b0;
      opdata1_i = 32'd100;
      opdata2_i = 32'd7;
      start_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_i = 1'b0;
      wait_ready(n);
      chk("pulse lat", 64'(n), 64'd32);
      chk("pulse res", result_o, {32'd2, 32'd14});
      @(posedge clk);
      #1;
      chk("pulse end", 64'(ready_o), 64'd0);

      // reset mid-operation
      @(negedge clk);
      opdata1_i = 32'd100;
      opdata2_i = 32'd7;
      start_i = 1'b1;
      @(posedge clk);
      repeat (19) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst mid rdy", 64'(ready_o), 64'd0);
      chk("rst mid res", result_o, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      start_i = 1'b0;
      do_div(1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 0, "after rst");

      for (int i = 0; i < 40; i++) begin
         s = 1'($urandom);
         a = pick($urandom_range(0, 3));
         b = pick($urandom_range(0, 3));
         do_div(s, a, b, ref_div(s, a, b), $urandom_range(0, 2), "rand");
      end

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
